// File: rtl/drap_imem.sv
// drap_imem: 128 x 32 single-port instruction memory with a registered, write-first read port.
// Optional even-parity protection per word is enabled by defining DRAP_IMEM_PARITY_EN.
module drap_imem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
`ifdef DRAP_IMEM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // Write-first: a write returns its own data on the same edge.
  always_comb begin
    data_out_d = mem_q[address];
    if (write) begin
      data_out_d = data_in;
    end else begin
      data_out_d = mem_q[address];
    end
  end

  // Storage array and output register; reset wipes every word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      if (write) begin
        mem_q[address] <= data_in;
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef DRAP_IMEM_PARITY_EN
  // Parity bits live in a packed vector so a single stored bit is easy to reach.
  logic [DEPTH-1:0] par_q;
  logic             parity_err_q;
  logic             parity_err_d;

  // A mismatch is only meaningful on reads; writes always report clean.
  always_comb begin
    parity_err_d = 1'b0;
    if (write) begin
      parity_err_d = 1'b0;
    end else begin
      parity_err_d = par_q[address] ^ even_parity(mem_q[address]);
    end
  end

  // Parity storage and the error flag, registered alongside data_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q        <= '0;
      parity_err_q <= 1'b0;
    end else begin
      if (write) begin
        par_q[address] <= even_parity(data_in);
      end
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_drap_imem.sv
// Scoreboard bench for drap_imem: stimulus pushes expected read data, a monitor pops and compares.
module tb_drap_imem;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [6:0]  address;
  logic        write;
  logic [31:0] data_out;
`ifdef DRAP_IMEM_PARITY_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] val;
    logic        perr;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  drap_imem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .address    (address),
    .write      (write),
`ifdef DRAP_IMEM_PARITY_EN
    .parity_err (parity_err),
`endif
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access at the falling edge and record what the next rising edge must produce.
  task automatic step(input logic rst, input logic wr, input logic [6:0] addr,
                      input logic [31:0] din, input logic [31:0] exp_val,
                      input logic exp_perr, input string name);
    exp_t e;
    @(negedge clk);
    rst_n   = rst;
    write   = wr;
    address = addr;
    data_in = din;
    e.val  = exp_val;
    e.perr = exp_perr;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge yields one result, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e.val) begin
          n_fail++;
          $display("FAIL %s: data_out=%h expected=%h", e.name, data_out, e.val);
        end
`ifdef DRAP_IMEM_PARITY_EN
        n_checks++;
        if (parity_err !== e.perr) begin
          n_fail++;
          $display("FAIL %s_perr: parity_err=%b expected=%b", e.name, parity_err, e.perr);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    address = 7'd0;
    data_in = 32'h0000_0000;

    // Reset held for two edges, then reads of a cleared memory.
    step(1'b0, 1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 1'b0, "reset0");
    step(1'b0, 1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 1'b0, "reset1");
    step(1'b1, 1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 1'b0, "rd0_clr");
    step(1'b1, 1'b0, 7'd1,   32'h0000_0000, 32'h0000_0000, 1'b0, "rd1_clr");
    step(1'b1, 1'b0, 7'd127, 32'h0000_0000, 32'h0000_0000, 1'b0, "rd127_clr");

    // Writes with write-first read-back.
    step(1'b1, 1'b1, 7'd0,   32'h5555_5555, 32'h5555_5555, 1'b0, "wr0");
    step(1'b1, 1'b1, 7'd1,   32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, "wr1");
    step(1'b1, 1'b1, 7'd126, 32'h5555_5555, 32'h5555_5555, 1'b0, "wr126");
    step(1'b1, 1'b1, 7'd127, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, "wr127");

    // Reads after writes, including an untouched location.
    step(1'b1, 1'b0, 7'd0,   32'h0000_0000, 32'h5555_5555, 1'b0, "rd0");
    step(1'b1, 1'b0, 7'd1,   32'h0000_0000, 32'hAAAA_AAAA, 1'b0, "rd1");
    step(1'b1, 1'b0, 7'd32,  32'h0000_0000, 32'h0000_0000, 1'b0, "rd32");
    step(1'b1, 1'b0, 7'd126, 32'h0000_0000, 32'h5555_5555, 1'b0, "rd126");
    step(1'b1, 1'b0, 7'd127, 32'h0000_0000, 32'hAAAA_AAAA, 1'b0, "rd127");

    // Overwrite then immediate read; data_out must hold through the low phase.
    step(1'b1, 1'b1, 7'd5,   32'h1234_5678, 32'h1234_5678, 1'b0, "wr5a");
    step(1'b1, 1'b1, 7'd5,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "wr5b");
    step(1'b1, 1'b0, 7'd5,   32'h0000_0000, 32'hDEAD_BEEF, 1'b0, "rd5");
    @(negedge clk);
    n_checks++;
    if (data_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd5_stable: data_out=%h expected=%h", data_out, 32'hDEAD_BEEF);
    end

    // Mid-sequence reset with a competing write.
    step(1'b1, 1'b1, 7'd64,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "wr64");
    step(1'b0, 1'b1, 7'd64,  32'h0000_0001, 32'h0000_0000, 1'b0, "rst_mid");
    step(1'b1, 1'b0, 7'd64,  32'h0000_0000, 32'h0000_0000, 1'b0, "rd64_rst");
    step(1'b1, 1'b0, 7'd127, 32'h0000_0000, 32'h0000_0000, 1'b0, "rd127_rst");
    step(1'b1, 1'b0, 7'd5,   32'h0000_0000, 32'h0000_0000, 1'b0, "rd5_rst");

`ifdef DRAP_IMEM_PARITY_EN
    step(1'b1, 1'b1, 7'd3,   32'h0000_0001, 32'h0000_0001, 1'b0, "wr3");
    step(1'b1, 1'b0, 7'd3,   32'h0000_0000, 32'h0000_0001, 1'b0, "rd3_ok");
    @(negedge clk);
    force dut.par_q[3] = 1'b0;
    step(1'b1, 1'b0, 7'd3,   32'h0000_0000, 32'h0000_0001, 1'b1, "rd3_bad");
    @(negedge clk);
    release dut.par_q[3];
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
